operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DB_COUNT, default 1000000, is the number of consecutive clk cycles a changed button level must persist to be accepted (10 ms at 100 MHz; benches use 4).
REQ-002 clk  in  1  single clock; all flops rise-edge triggered on clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 switch_data  in  16  operand value from the switches; quasi-static, sampled directly without synchronisation.
REQ-005 op_select  in  3  operation code from the switches.
REQ-006 btn_raw  in  1  raw, bouncy, asynchronous execute button.
REQ-007 core_ready  in  1  calculator core result-valid indication.
REQ-008 operand_a  out  16  latched first operand.
REQ-009 operand_b  out  16  latched second operand.
REQ-010 operation  out  3  latched operation code.
REQ-011 start  out  1  single-cycle request to the calculator core.
REQ-012 busy  out  1  high while a request is outstanding (ISSUE or WAIT).
REQ-013 entry_state  out  2  current FSM state encoding, for status LEDs.

Function
REQ-014 btn_raw passes through a two-flop synchroniser (s1, s2) before any other use.
REQ-015 Debouncer: stable level register plus counter of width ceil(log2(DB_COUNT)).
- On each edge where s2 != stable: if count == DB_COUNT-1, stable <= s2 and count <= 0; else count increments.
- On each edge where s2 == stable: count <= 0.
REQ-016 press is high for exactly one cycle: the cycle in which stable is 1 and its one-cycle-delayed copy is 0. Release generates no press; a held button generates exactly one press.
REQ-017 Any s2 excursion shorter than DB_COUNT consecutive cycles leaves stable unchanged.
REQ-018 FSM states and encodings: GET_A=00, GET_B=01, ISSUE=10, WAIT=11; entry_state equals the encoding.
REQ-019 GET_A, on a clock edge with press=1:
- operand_a <= switch_data; operation <= op_select.
- If op_select is 110 or 111 (unary): operand_b <= 0, go to ISSUE.
- Otherwise: go to GET_B.
REQ-020 GET_B, on a clock edge with press=1: operand_b <= switch_data, go to ISSUE.
REQ-021 ISSUE lasts exactly one cycle; start = 1 throughout that cycle (decoded from the state register, glitch-free); next state is WAIT.
REQ-022 WAIT: on an edge with core_ready=1, go to GET_A; otherwise stay.
REQ-023 press is ignored in ISSUE and WAIT, including when it coincides with core_ready=1 in WAIT; that press is discarded, not queued.
REQ-024 core_ready is ignored in GET_A, GET_B and ISSUE.
REQ-025 operand_a, operand_b and operation change only on the capture edges in REQ-019 and REQ-020; they are held stable from ISSUE through WAIT.
REQ-026 Latency: with btn_raw rising before edge 0 and held, stable rises at edge DB_COUNT+1 and capture occurs at edge DB_COUNT+2. If that capture enters ISSUE, start is high between edges DB_COUNT+2 and DB_COUNT+3.

Reset
REQ-027 While reset is high, asynchronously and independent of clk, the following are cleared:
- state <= GET_A; operand_a, operand_b, operation <= 0.
- start <= 0, busy <= 0, entry_state <= 00.
- s1, s2, stable, its delayed copy and count <= 0.
REQ-028 Reset asserted mid-operation, in any state, aborts the request; no start is issued afterwards until a new full entry sequence completes.
REQ-029 A button held through reset release produces one press after the debounce interval, treated as a fresh press in GET_A.

Verification (DB_COUNT=4)
REQ-030 Binary op: press with switch_data=0x0012, op_select=000; press with switch_data=0x0034 -> one start pulse with operand_a=0x0012, operand_b=0x0034, operation=000, entry_state=10 then 11.
REQ-031 Unary op: press with switch_data=0x00FF, op_select=111 -> start without visiting GET_B; operand_b=0x0000.
REQ-032 Bounce: btn_raw toggles every 2 cycles for 20 cycles, then holds 1 for 10 cycles -> exactly one capture; a 3-cycle glitch alone -> no capture.
REQ-033 Busy lockout: press in WAIT, and a press on the same edge as core_ready=1 -> no capture, operands unchanged, state returns to 00.
REQ-034 Reset in WAIT with operands non-zero -> all outputs 0 immediately, with no clk edge required; the next sequence operates normally.
REQ-035 Timing: btn_raw rises before edge 0 in GET_B -> capture at edge 6, start high for exactly cycle 6-7, busy high from edge 6.

Source files
------------

// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
// Front end of a switch-driven calculator. A bouncy push button is
// synchronised and debounced into a single-cycle press. Each press latches
// the switch value as an operand. A small FSM then hands the latched request
// to the calculator core.
//
// Ports
//   clk          in   1   single rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   switch_data  in  16   operand value from the switches (quasi-static)
//   op_select    in   3   operation code from the switches
//   btn_raw      in   1   raw asynchronous execute button
//   core_ready   in   1   calculator core result-valid
//   operand_a    out 16   latched first operand
//   operand_b    out 16   latched second operand (0 for unary ops)
//   operation    out  3   latched operation code
//   start        out  1   one-cycle request to the core
//   busy         out  1   high while a request is outstanding
//   entry_state  out  2   FSM state encoding for status LEDs
// -----------------------------------------------------------------------------
module operand_entry #(
   parameter int DB_COUNT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] switch_data,
   input  logic [2:0]  op_select,
   input  logic        btn_raw,
   input  logic        core_ready,
   output logic [15:0] operand_a,
   output logic [15:0] operand_b,
   output logic [2:0]  operation,
   output logic        start,
   output logic        busy,
   output logic [1:0]  entry_state
);

   localparam int            CW       = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   typedef enum logic [1:0] {
      ST_GET_A = 2'b00,
      ST_GET_B = 2'b01,
      ST_ISSUE = 2'b10,
      ST_WAIT  = 2'b11
   } state_t;

   logic          r_s1;
   logic          r_s2;
   logic          r_stable;
   logic          r_stable_d;
   logic [CW-1:0] r_count;
   logic          w_press;
   logic          w_unary;
   logic          w_cap_a;
   logic          w_cap_b;
   logic          w_start_nxt;
   logic          w_busy_nxt;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_operand_a;
   logic [15:0]   r_operand_b;
   logic [2:0]    r_operation;
   logic          r_start;
   logic          r_busy;

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= btn_raw;
         r_s2 <= r_s1;
      end
   end

   // Debouncer: accept a new level only after it has persisted DB_COUNT cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_count    <= '0;
      end else begin
         r_stable_d <= r_stable;
         if (r_s2 != r_stable) begin
            if (r_count == CNT_LAST) begin
               r_stable <= r_s2;
               r_count  <= '0;
            end else begin
               r_count <= r_count + CW'(1);
            end
         end else begin
            r_count <= '0;
         end
      end
   end

   // Rising edge of the debounced level; a held button yields one press.
   assign w_press = r_stable & ~r_stable_d;
   // Op codes 110 and 111 take a single operand.
   assign w_unary = (op_select[2:1] == 2'b11);

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_GET_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; presses outside GET_A/GET_B are dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_GET_A: begin
            if (w_press) begin
               w_state_nxt = w_unary ? ST_ISSUE : ST_GET_B;
            end else begin
               w_state_nxt = ST_GET_A;
            end
         end
         ST_GET_B: begin
            if (w_press) begin
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_GET_B;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (core_ready) begin
               w_state_nxt = ST_GET_A;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: w_state_nxt = ST_GET_A;
      endcase
   end

   // FSM output decode, computed from the next state so the flops below
   // present start/busy in the same cycle as the state they describe.
   always_comb begin
      w_start_nxt = (w_state_nxt == ST_ISSUE);
      w_busy_nxt  = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
      w_cap_a     = (r_state == ST_GET_A) && w_press;
      w_cap_b     = (r_state == ST_GET_B) && w_press;
   end

   // Registered request strobes, glitch-free toward the core.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_start <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_start <= w_start_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Operand capture; values are held untouched from ISSUE through WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_operand_a <= 16'h0000;
         r_operand_b <= 16'h0000;
         r_operation <= 3'b000;
      end else begin
         if (w_cap_a) begin
            r_operand_a <= switch_data;
            r_operation <= op_select;
            if (w_unary) begin
               r_operand_b <= 16'h0000;
            end else begin
               r_operand_b <= r_operand_b;
            end
         end else if (w_cap_b) begin
            r_operand_b <= switch_data;
         end else begin
            r_operand_b <= r_operand_b;
         end
      end
   end

   assign operand_a   = r_operand_a;
   assign operand_b   = r_operand_b;
   assign operation   = r_operation;
   assign start       = r_start;
   assign busy        = r_busy;
   assign entry_state = r_state;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] switch_data;
   logic [2:0]  op_select;
   logic        btn_raw;
   logic        core_ready;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [2:0]  operation;
   logic        start;
   logic        busy;
   logic [1:0]  entry_state;

   operand_entry #(.DB_COUNT(DB)) dut (
      .clk(clk), .reset(reset), .switch_data(switch_data), .op_select(op_select),
      .btn_raw(btn_raw), .core_ready(core_ready), .operand_a(operand_a),
      .operand_b(operand_b), .operation(operation), .start(start), .busy(busy),
      .entry_state(entry_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int dut_starts = 0;
   int mdl_starts = 0;

   // Reference model: state codes 0=GET_A 1=GET_B 2=ISSUE 3=WAIT
   logic [1:0]  m_st;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_op;
   bit          m_s1, m_s2, m_stable, m_stable_d;
   int          m_run;
   logic [38:0] m_vec;
   logic [38:0] d_vec;

   assign d_vec = {entry_state, busy, start, operand_a, operand_b, operation};

   task automatic model_clear();
      m_st = 2'd0; m_a = 16'h0; m_b = 16'h0; m_op = 3'd0;
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0; m_run = 0;
      m_vec = 39'd0;
   endtask

   // One clock edge: advance the model with pre-edge inputs, then settle.
   task automatic tick();
      bit press_m;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         press_m = m_stable && !m_stable_d;
         case (m_st)
            2'd0: if (press_m) begin
                     m_a = switch_data; m_op = op_select;
                     if (op_select >= 3'd6) begin m_b = 16'h0; m_st = 2'd2; end
                     else m_st = 2'd1;
                  end
            2'd1: if (press_m) begin m_b = switch_data; m_st = 2'd2; end
            2'd2: m_st = 2'd3;
            default: if (core_ready) m_st = 2'd0;
         endcase
         // level accepted once it differs for DB consecutive edges
         m_stable_d = m_stable;
         if (m_s2 != m_stable) begin
            m_run++;
            if (m_run == DB) begin m_stable = m_s2; m_run = 0; end
         end else m_run = 0;
         m_s2 = m_s1;
         m_s1 = btn_raw;
      end
      m_vec = {m_st, m_st[1], (m_st == 2'd2), m_a, m_b, m_op};
      #1;
      if (start) dut_starts++;
      if (m_st == 2'd2) mdl_starts++;
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_raw = 1'b0; core_ready = 1'b0;
      switch_data = 16'h0; op_select = 3'd0;
      model_clear();
      #2;
      checks++;
      if (d_vec !== 39'd0) begin errors++; $display("FAIL reset_async: got %h want 0", d_vec); end
      repeat (2) tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL reset_idle: got %h want %h", d_vec, m_vec); end
      end
   endtask

   task automatic test_binary();
      int s0 = dut_starts;
      switch_data = 16'h0012; op_select = 3'b000;
      for (int i = 0; i < 16; i++) begin
         btn_raw = (i < 8); tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL binary_a t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      switch_data = 16'h0034; op_select = 3'b101;
      for (int i = 0; i < 16; i++) begin
         btn_raw = (i < 8); tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL binary_b t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      checks++;
      if ({operand_a, operand_b, operation, entry_state, busy, start} !== {16'h0012, 16'h0034, 3'b000, 2'b11, 1'b1, 1'b0})
         begin errors++; $display("FAIL binary_result: got %h %h %b %b", operand_a, operand_b, operation, entry_state); end
      checks++;
      if (dut_starts - s0 !== 1) begin errors++; $display("FAIL binary_starts: got %0d want 1", dut_starts - s0); end
      core_ready = 1'b1; tick(); core_ready = 1'b0;
      checks++;
      if (entry_state !== 2'b00) begin errors++; $display("FAIL binary_return: got %b want 00", entry_state); end
   endtask

   task automatic test_unary();
      int s0 = dut_starts;
      bit saw_b = 0;
      switch_data = 16'h00FF; op_select = 3'b111;
      for (int i = 0; i < 16; i++) begin
         btn_raw = (i < 8); tick(); checks++;
         if (entry_state === 2'b01) saw_b = 1;
         if (d_vec !== m_vec) begin errors++; $display("FAIL unary t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      checks++;
      if (saw_b) begin errors++; $display("FAIL unary_no_get_b: got visited want skipped"); end
      checks++;
      if ({operand_a, operand_b, operation, entry_state} !== {16'h00FF, 16'h0000, 3'b111, 2'b11})
         begin errors++; $display("FAIL unary_result: got %h %h %b %b", operand_a, operand_b, operation, entry_state); end
      checks++;
      if (dut_starts - s0 !== 1) begin errors++; $display("FAIL unary_starts: got %0d want 1", dut_starts - s0); end
      core_ready = 1'b1; tick(); core_ready = 1'b0;
   endtask

   task automatic test_bounce();
      logic [15:0] d = 16'($urandom);
      logic [15:0] ob;
      switch_data = d; op_select = 3'b010;
      for (int i = 0; i < 40; i++) begin
         btn_raw = (i < 20) ? ((i / 2) % 2 == 0) : (i < 30);
         tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL bounce t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      checks++;
      if ({entry_state, operand_a} !== {2'b01, d}) begin errors++; $display("FAIL bounce_one_capture: got %b %h want 01 %h", entry_state, operand_a, d); end
      ob = operand_b;
      switch_data = ~d;
      for (int i = 0; i < 13; i++) begin
         btn_raw = (i < 3); tick();
      end
      checks++;
      if ({entry_state, operand_b} !== {2'b01, ob}) begin errors++; $display("FAIL glitch_no_capture: got %b %h want 01 %h", entry_state, operand_b, ob); end
   endtask

   // Entered in GET_B with the button settled low.
   task automatic test_timing();
      logic [15:0] d = 16'($urandom);
      logic [1:0]  exp_st;
      switch_data = d;
      btn_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_st = (e < 6) ? 2'b01 : ((e == 6) ? 2'b10 : 2'b11);
         checks++;
         if ({entry_state, start, busy} !== {exp_st, (e == 6), (e >= 6)})
            begin errors++; $display("FAIL timing edge %0d: got st=%b start=%b busy=%b want st=%b", e, entry_state, start, busy, exp_st); end
         if (e == 6) begin
            checks++;
            if (operand_b !== d) begin errors++; $display("FAIL timing_capture: got %h want %h", operand_b, d); end
         end
      end
      for (int i = 0; i < 10; i++) begin btn_raw = 1'b0; tick(); end
      core_ready = 1'b1; tick(); core_ready = 1'b0;
   endtask

   task automatic test_busy_lockout();
      logic [15:0] a = 16'($urandom) | 16'h0001;
      logic [15:0] b = 16'($urandom) | 16'h0100;
      int n = 0;
      switch_data = a; op_select = 3'b001;
      for (int i = 0; i < 16; i++) begin btn_raw = (i < 8); tick(); end
      switch_data = b;
      for (int i = 0; i < 16; i++) begin btn_raw = (i < 8); tick(); end
      switch_data = ~a; op_select = 3'b110;
      for (int i = 0; i < 16; i++) begin
         btn_raw = (i < 8); tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL lockout_wait t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      checks++;
      if ({entry_state, operand_a, operand_b, operation} !== {2'b11, a, b, 3'b001})
         begin errors++; $display("FAIL lockout_wait_press: got %b %h %h %b", entry_state, operand_a, operand_b, operation); end
      btn_raw = 1'b1;
      while (!(m_stable && !m_stable_d) && n < 20) begin tick(); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL lockout_press_timeout: got %0d edges want < 20", n); end
      core_ready = 1'b1; tick(); core_ready = 1'b0;
      checks++;
      if ({entry_state, operand_a, operand_b, operation} !== {2'b00, a, b, 3'b001})
         begin errors++; $display("FAIL lockout_coincide: got %b %h %h %b", entry_state, operand_a, operand_b, operation); end
      for (int i = 0; i < 14; i++) begin btn_raw = (i < 4); tick(); end
      checks++;
      if ({entry_state, operand_a, operand_b} !== {2'b00, a, b})
         begin errors++; $display("FAIL lockout_not_queued: got %b %h %h", entry_state, operand_a, operand_b); end
   endtask

   task automatic test_reset_wait();
      logic [15:0] a = 16'($urandom) | 16'h0001;
      logic [15:0] b = 16'($urandom) | 16'h0001;
      int s0;
      switch_data = a; op_select = 3'b011;
      for (int i = 0; i < 16; i++) begin btn_raw = (i < 8); tick(); end
      switch_data = b;
      for (int i = 0; i < 16; i++) begin btn_raw = (i < 8); tick(); end
      checks++;
      if (entry_state !== 2'b11) begin errors++; $display("FAIL rstwait_setup: got %b want 11", entry_state); end
      btn_raw = 1'b1;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (d_vec !== 39'd0) begin errors++; $display("FAIL rstwait_async: got %h want 0", d_vec); end
      model_clear();
      repeat (3) tick();
      reset = 1'b0;
      s0 = dut_starts;
      a = 16'($urandom); b = 16'($urandom);
      switch_data = a; op_select = 3'b100;
      for (int i = 0; i < 22; i++) begin
         btn_raw = (i < 12); tick(); checks++;
         if (d_vec !== m_vec) begin errors++; $display("FAIL rstwait_held t=%0t: got %h want %h", $time, d_vec, m_vec); end
      end
      checks++;
      if ({entry_state, operand_a, operation} !== {2'b01, a, 3'b100})
         begin errors++; $display("FAIL rstwait_fresh_press: got %b %h %b", entry_state, operand_a, operation); end
      switch_data = b;
      for (int i = 0; i < 16; i++) begin btn_raw = (i < 8); tick(); end
      checks++;
      if ({entry_state, operand_a, operand_b, dut_starts - s0} !== {2'b11, a, b, 32'd1})
         begin errors++; $display("FAIL rstwait_resume: got %b %h %h starts=%0d", entry_state, operand_a, operand_b, dut_starts - s0); end
      core_ready = 1'b1; tick(); core_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         int len = $urandom_range(1, 9);
         btn_raw = 1'($urandom_range(0, 1));
         switch_data = 16'($urandom);
         op_select = 3'($urandom_range(0, 7));
         for (int k = 0; k < len; k++) begin
            core_ready = ($urandom_range(0, 3) == 0);
            tick(); checks++;
            if (d_vec !== m_vec) begin errors++; $display("FAIL random t=%0t: got %h want %h", $time, d_vec, m_vec); end
         end
      end
      core_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_binary();
      test_unary();
      test_bounce();
      test_timing();
      test_busy_lockout();
      test_reset_wait();
      test_random();
      checks++;
      if (dut_starts !== mdl_starts) begin errors++; $display("FAIL start_count: got %0d want %0d", dut_starts, mdl_starts); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
